stopwatch_counter: RTL



---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/stopwatch_counter_bcd_digit.sv | 32 +++
 rtl/stopwatch_counter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timing core.
package stopwatch_pkg;

    // Run-control state of the stopwatch.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

    // Code the downstream 7-segment decoder renders as an unlit digit.
    localparam logic [3:0] BCD_BLANK       = 4'hF;
    localparam logic [3:0] BCD_MAX_DIGIT   = 4'd9;
    // 10 ms tick at a 100 MHz system clock.
    localparam int         TICK_DIV_100MHZ = 1_000_000;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One decimal digit of the elapsed-time count: wraps 9 -> 0 and emits a
// carry in the same cycle as the wrapping increment.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] r_q;
    logic       w_at_max;

    assign w_at_max = (r_q == BCD_MAX_DIGIT);
    assign q        = r_q;
    assign carry    = inc & w_at_max;

    // Digit register: cleared by reset or clear, otherwise steps on inc.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 4'd0;
        end else if (clr) begin
            r_q <= 4'd0;
        end else if (inc) begin
            r_q <= w_at_max ? 4'd0 : r_q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timing core: start/stop edge detect, run-control FSM, 10 ms
// prescaler, four chained BCD digits (SS.cc) with saturation at 99.99 and
// optional blanking of a leading zero in the tens-of-seconds digit.
//
// Handshake note: there is no valid/ready traffic here; start_stop and clear
// are debounced levels sampled every clock, and all outputs are plain
// combinational views of registers, valid in every cycle.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_100MHZ,
    parameter bit BLANK_LZ = 1'b1
)(
    input  logic      clk,
    input  logic      reset,
    input  logic      start_stop,
    input  logic      clear,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic      running,
    output logic      overflow,
    output sw_state_t dbg_state
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_t       r_state;
    sw_state_t       w_next_state;
    logic            r_ss_q;
    logic            r_overflow;
    logic [PW-1:0]   r_presc;
    logic            w_ss_edge;
    logic            w_tick;
    logic            w_all_nine;
    logic            w_sat;
    logic [3:0]      w_inc;
    logic [3:0]      w_carry;
    logic [3:0][3:0] w_digit;

    assign w_ss_edge  = start_stop & ~r_ss_q;
    assign w_tick     = (r_state == RUNNING) && (r_presc == PRESC_LAST);
    assign w_all_nine = (w_digit[0] == BCD_MAX_DIGIT) && (w_digit[1] == BCD_MAX_DIGIT) &&
                        (w_digit[2] == BCD_MAX_DIGIT) && (w_digit[3] == BCD_MAX_DIGIT);
    // A tick at 99.99 saturates instead of incrementing, so the chain is
    // never allowed to roll the count over to 00.00.
    assign w_sat      = w_tick & w_all_nine;
    assign w_inc[0]   = w_tick & ~w_sat;
    assign w_inc[3:1] = w_carry[2:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk   (clk),
                .reset (reset),
                .clr   (clear),
                .inc   (w_inc[gi]),
                .q     (w_digit[gi]),
                .carry (w_carry[gi])
            );
        end
    endgenerate

    // Registered copy of start_stop; keeps tracking during clear so that
    // releasing clear with the button held does not look like a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ss_q <= 1'b0;
        end else begin
            r_ss_q <= start_stop;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: clear beats saturation, saturation beats a button edge;
    // once saturated the button is ignored until clear.
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = IDLE;
        end else if (w_sat) begin
            w_next_state = PAUSED;
        end else if (w_ss_edge && !r_overflow) begin
            case (r_state)
                IDLE:    w_next_state = RUNNING;
                RUNNING: w_next_state = PAUSED;
                PAUSED:  w_next_state = RUNNING;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        running   = (r_state == RUNNING);
        dbg_state = r_state;
    end

    // Prescaler: counts only while running, holds its phase while paused so
    // a resume continues the interrupted 10 ms interval.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_presc <= '0;
        end else if (r_state == IDLE) begin
            r_presc <= '0;
        end else if (r_state == RUNNING) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end
    end

    // Sticky overflow flag. The d3 carry cannot fire while saturation gates
    // the chain; it is folded in so a rollover could never go unflagged.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_overflow <= 1'b0;
        end else if (w_sat || w_carry[3]) begin
            r_overflow <= 1'b1;
        end
    end

    // Digit outputs with optional leading-zero blanking on the tens digit.
    always_comb begin
        d3 = (BLANK_LZ && (w_digit[3] == 4'd0)) ? BCD_BLANK : w_digit[3];
        d2 = w_digit[2];
        d1 = w_digit[1];
        d0 = w_digit[0];
        overflow = r_overflow;
    end

endmodule
